// File: rtl/tmds_deser_align_if.sv
// Lane-side bundle for the TMDS 1:10 deserializer: serial input plus
// recovered word, strobe and alignment status.
interface tmds_deser_align_if;
  logic       tmds_lane;
  logic [9:0] par_data;
  logic       par_valid;
  logic       locked;
  logic [3:0] slip_count;

  // Driver of the serial lane / consumer of recovered words
  modport master (
    output tmds_lane,
    input  par_data,
    input  par_valid,
    input  locked,
    input  slip_count
  );

  // Deserializer side
  modport slave (
    input  tmds_lane,
    output par_data,
    output par_valid,
    output locked,
    output slip_count
  );
endinterface

// File: rtl/tmds_deser_align.sv
// 1:10 TMDS lane deserializer with control-token word alignment.
// Bits arrive LSB-first; a word is emitted every 10 bit clocks. The
// alignment FSM slips the word boundary one bit at a time until a run of
// control tokens is seen, then holds lock until tokens stop appearing.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_SEARCH | hunting for alignment; counts hits/words, slips on timeout
// ST_LOCKED | aligned; counts consecutive non-token words for loss
module tmds_deser_align #(
  parameter int LOCK_HITS    = 8,
  parameter int SEARCH_WORDS = 16,
  parameter int LOSS_WORDS   = 4096
) (
  input  logic               bit_clock,
  input  logic               rst,
  tmds_deser_align_if.slave  bus
);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [7:0]  LP_LOCK_HITS    = 8'(LOCK_HITS);
  localparam logic [7:0]  LP_SEARCH_WORDS = 8'(SEARCH_WORDS);
  localparam logic [15:0] LP_LOSS_WORDS   = 16'(LOSS_WORDS);
  localparam logic [1:0]  LP_SETTLE_WORDS = 2'd2;

  // sr[0] would fall off on the capture edge anyway, so only sr[9:1] is kept
  logic [9:1] r_sr;
  logic [3:0] r_bcnt;
  logic [9:0] r_par_data;
  logic       r_par_valid;

  state_t      r_state;
  logic        r_slip;
  logic        r_locked;
  logic [3:0]  r_slip_count;
  logic [1:0]  r_settle;
  logic [7:0]  r_hit_cnt;
  logic [7:0]  r_word_cnt;
  logic [15:0] r_miss_cnt;

  logic        w_hit;
  logic [7:0]  w_hit_cnt_nxt;
  logic [7:0]  w_word_cnt_nxt;
  logic [15:0] w_miss_cnt_nxt;
  logic [3:0]  w_slip_count_inc;

  assign w_hit = (r_par_data == 10'h354) || (r_par_data == 10'h0AB) ||
                 (r_par_data == 10'h154) || (r_par_data == 10'h2AB);

  // Saturating next values so the counters never wrap past their limits
  assign w_hit_cnt_nxt  = !w_hit ? 8'd0 :
                          (r_hit_cnt == LP_LOCK_HITS) ? r_hit_cnt : r_hit_cnt + 8'd1;
  assign w_word_cnt_nxt = (r_word_cnt == LP_SEARCH_WORDS) ? r_word_cnt : r_word_cnt + 8'd1;
  assign w_miss_cnt_nxt = w_hit ? 16'd0 :
                          (r_miss_cnt == LP_LOSS_WORDS) ? r_miss_cnt : r_miss_cnt + 16'd1;
  assign w_slip_count_inc = (r_slip_count == 4'd9) ? 4'd0 : r_slip_count + 4'd1;

  // Serial shift, bit counter with slip hold, and word capture on bcnt==9
  always_ff @(posedge bit_clock or posedge rst) begin
    if (rst) begin
      r_sr        <= '0;
      r_bcnt      <= 4'd0;
      r_par_data  <= 10'd0;
      r_par_valid <= 1'b0;
    end else begin
      r_sr        <= {bus.tmds_lane, r_sr[9:2]};
      r_par_valid <= 1'b0;
      if (r_bcnt == 4'd9) begin
        r_par_data  <= {bus.tmds_lane, r_sr[9:1]};
        r_par_valid <= 1'b1;
      end
      // Holding the counter for one edge pushes every later boundary one bit late
      if (!r_slip) begin
        r_bcnt <= (r_bcnt == 4'd9) ? 4'd0 : r_bcnt + 4'd1;
      end
    end
  end

  // Alignment FSM: evaluates each word during its par_valid cycle
  always_ff @(posedge bit_clock or posedge rst) begin
    if (rst) begin
      r_state      <= ST_SEARCH;
      r_slip       <= 1'b0;
      r_locked     <= 1'b0;
      r_slip_count <= 4'd0;
      r_settle     <= 2'd0;
      r_hit_cnt    <= 8'd0;
      r_word_cnt   <= 8'd0;
      r_miss_cnt   <= 16'd0;
    end else begin
      r_slip <= 1'b0;
      if (r_par_valid) begin
        if (r_settle != 2'd0) begin
          // Words straddling a slip are passed through but not judged
          r_settle <= r_settle - 2'd1;
        end else begin
          case (r_state)
            ST_SEARCH: begin
              if (w_hit_cnt_nxt == LP_LOCK_HITS) begin
                r_state    <= ST_LOCKED;
                r_locked   <= 1'b1;
                r_hit_cnt  <= 8'd0;
                r_word_cnt <= 8'd0;
                r_miss_cnt <= 16'd0;
              end else if (w_word_cnt_nxt == LP_SEARCH_WORDS) begin
                r_slip       <= 1'b1;
                r_slip_count <= w_slip_count_inc;
                r_settle     <= LP_SETTLE_WORDS;
                r_hit_cnt    <= 8'd0;
                r_word_cnt   <= 8'd0;
              end else begin
                r_hit_cnt  <= w_hit_cnt_nxt;
                r_word_cnt <= w_word_cnt_nxt;
              end
            end
            ST_LOCKED: begin
              if (w_miss_cnt_nxt == LP_LOSS_WORDS) begin
                r_state    <= ST_SEARCH;
                r_locked   <= 1'b0;
                r_hit_cnt  <= 8'd0;
                r_word_cnt <= 8'd0;
                r_miss_cnt <= 16'd0;
              end else begin
                r_miss_cnt <= w_miss_cnt_nxt;
              end
            end
            default: begin
              r_state  <= ST_SEARCH;
              r_locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.par_data   = r_par_data;
  assign bus.par_valid  = r_par_valid;
  assign bus.locked     = r_locked;
  assign bus.slip_count = r_slip_count;

endmodule

// File: tb/tb_tmds_deser_align.sv
// Bench for tmds_deser_align: random and patterned serial streams checked
// against a word-level reference model built from the bit history.
module tb_tmds_deser_align;

  localparam int LOCK_HITS    = 8;
  localparam int SEARCH_WORDS = 16;
  localparam int LOSS_WORDS   = 16;

  logic bit_clock = 1'b0;
  logic rst       = 1'b1;

  tmds_deser_align_if u_if ();

  tmds_deser_align #(
    .LOCK_HITS   (LOCK_HITS),
    .SEARCH_WORDS(SEARCH_WORDS),
    .LOSS_WORDS  (LOSS_WORDS)
  ) u_dut (
    .bit_clock(bit_clock),
    .rst      (rst),
    .bus      (u_if)
  );

  always #5 bit_clock = ~bit_clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: bit history, expected capture cycle, alignment counters
  bit bits[$];
  int n_edge;
  int next_cap;
  bit pending;
  int pending_word;
  int m_settle, m_hit, m_word, m_miss, m_sc;
  bit m_locked;
  int last_valid, n_gap11;

  function automatic bit is_token(input int w);
    return (w == 'h354) || (w == 'h0AB) || (w == 'h154) || (w == 'h2AB);
  endfunction

  function automatic void model_reset();
    bits.delete();
    n_edge     = 0;
    next_cap   = 10;
    pending    = 1'b0;
    m_settle   = 0;
    m_hit      = 0;
    m_word     = 0;
    m_miss     = 0;
    m_sc       = 0;
    m_locked   = 1'b0;
    last_valid = 0;
    n_gap11    = 0;
  endfunction

  function automatic void model_eval(input int w);
    if (m_settle > 0) begin
      m_settle--;
      return;
    end
    if (!m_locked) begin
      m_hit  = is_token(w) ? ((m_hit < LOCK_HITS) ? m_hit + 1 : m_hit) : 0;
      m_word = (m_word < SEARCH_WORDS) ? m_word + 1 : m_word;
      if (m_hit >= LOCK_HITS) begin
        m_locked = 1'b1;
        m_hit    = 0;
        m_word   = 0;
        m_miss   = 0;
      end else if (m_word >= SEARCH_WORDS) begin
        m_sc     = (m_sc + 1) % 10;
        m_hit    = 0;
        m_word   = 0;
        m_settle = 2;
        next_cap = next_cap + 1;
      end
    end else begin
      m_miss = is_token(w) ? 0 : ((m_miss < LOSS_WORDS) ? m_miss + 1 : m_miss);
      if (m_miss >= LOSS_WORDS) begin
        m_locked = 1'b0;
        m_hit    = 0;
        m_word   = 0;
        m_miss   = 0;
      end
    end
  endfunction

  // Drive one bit, let the DUT take its edge, then compare on the falling edge
  task automatic step(input bit b);
    logic [9:0] w;
    bit         exp_valid;
    u_if.tmds_lane = b;
    bits.push_back(b);
    @(posedge bit_clock);
    n_edge++;
    @(negedge bit_clock);
    if (pending) begin
      pending = 1'b0;
      model_eval(pending_word);
    end
    exp_valid = (n_edge == next_cap);
    check_eq("par_valid", 32'(u_if.par_valid), 32'(exp_valid));
    if (exp_valid) begin
      for (int i = 0; i < 10; i++) w[i] = bits[n_edge - 10 + i];
      check_eq("par_data", 32'(u_if.par_data), 32'(w));
      pending      = 1'b1;
      pending_word = int'(w);
      next_cap     = next_cap + 10;
    end
    if (u_if.par_valid) begin
      if (last_valid != 0 && (n_edge - last_valid) == 11) n_gap11++;
      last_valid = n_edge;
    end
    check_eq("locked", 32'(u_if.locked), 32'(m_locked));
    check_eq("slip_count", 32'(u_if.slip_count), 32'(m_sc));
  endtask

  task automatic send_word(input int w, input int reps);
    logic [9:0] v;
    v = 10'(w);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < 10; i++) step(v[i]);
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_par_data"},   32'(u_if.par_data),   32'd0);
    check_eq({tag, "_par_valid"},  32'(u_if.par_valid),  32'd0);
    check_eq({tag, "_locked"},     32'(u_if.locked),     32'd0);
    check_eq({tag, "_slip_count"}, 32'(u_if.slip_count), 32'd0);
  endtask

  initial begin
    u_if.tmds_lane = 1'b0;
    model_reset();

    // Reset held with random lane activity
    for (int c = 0; c < 4; c++) begin
      u_if.tmds_lane = 1'($urandom_range(0, 1));
      @(negedge bit_clock);
      check_cleared("reset_hold");
    end
    rst = 1'b0;
    model_reset();

    // Aligned token stream from the first post-reset edge
    send_word('h354, 12);
    check_eq("aligned_locked", 32'(u_if.locked), 32'd1);
    check_eq("aligned_slips", 32'(u_if.slip_count), 32'd0);
    check_eq("aligned_data", 32'(u_if.par_data), 32'h354);

    // Periodic tokens keep lock alive
    for (int r = 0; r < 4; r++) begin
      send_word('h2CC, 15);
      send_word('h354, 1);
    end
    check_eq("recovery_locked", 32'(u_if.locked), 32'd1);
    check_eq("recovery_slips", 32'(u_if.slip_count), 32'd0);

    // Asynchronous reset between edges while locked
    check_eq("pre_areset_locked", 32'(u_if.locked), 32'd1);
    #2 rst = 1'b1;
    #1 check_cleared("async_reset");
    @(negedge bit_clock);
    check_cleared("async_reset_hold");
    rst = 1'b0;
    model_reset();

    // Token stream preceded by 3 filler bits: three slips to align
    for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)));
    send_word('h354, 80);
    check_eq("misalign_gaps11", 32'(n_gap11), 32'd3);
    check_eq("misalign_slips", 32'(u_if.slip_count), 32'd3);
    check_eq("misalign_locked", 32'(u_if.locked), 32'd1);
    check_eq("misalign_data", 32'(u_if.par_data), 32'h354);

    // Loss of tokens: lock drops, search resumes and slips wrap mod 10
    n_gap11 = 0;
    send_word('h2CC, 16);
    step(1'b0);
    check_eq("loss_locked", 32'(u_if.locked), 32'd0);
    send_word('h2CC, 230);
    check_eq("loss_still_unlocked", 32'(u_if.locked), 32'd0);
    check_eq("loss_gaps11_min", 32'(n_gap11 >= 12), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
